// File: rtl/clkgen_multi_if.sv
// Control and status bundle for clkgen_multi: per-channel enables, the shared
// limit write port, phase-align strobe and the divided outputs.
interface clkgen_multi_if #(
    parameter int NCH   = 4,
    parameter int CNT_W = 32,
    parameter int CH_W  = (NCH > 1) ? $clog2(NCH) : 1
);
    logic [NCH-1:0]   clken;
    logic             sync;
    logic             wr_en;
    logic [CH_W-1:0]  wr_ch;
    logic [CNT_W-1:0] wr_limit;
    logic [NCH-1:0]   clkout;
    logic [NCH-1:0]   tick;
    logic [NCH-1:0]   busy;

    modport master (
        output clken, sync, wr_en, wr_ch, wr_limit,
        input  clkout, tick, busy
    );

    modport slave (
        input  clken, sync, wr_en, wr_ch, wr_limit,
        output clkout, tick, busy
    );
endinterface

// File: rtl/clkgen_multi.sv
// Multi-channel programmable clock divider: NCH independent 50%-duty square
// waves with a rising-edge tick strobe, each with a runtime half-period limit.
module clkgen_multi_ch #(
    parameter int CNT_W     = 32,
    parameter int DEF_LIMIT = 25000
) (
    input  logic             clkin,
    input  logic             rst,
    input  logic             run,
    input  logic             sync,
    input  logic             wr_hit,
    input  logic [CNT_W-1:0] wr_limit,
    input  logic             en,
    output logic             clkout,
    output logic             tick,
    output logic             busy
);
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] limit;
    logic [CNT_W:0]   nxt;
    logic             active;

    // One extra bit so cnt+1 cannot wrap before the compare.
    assign nxt    = {1'b0, cnt} + (CNT_W+1)'(1);
    assign active = en && (limit != '0);

    always_ff @(posedge clkin or negedge rst) begin
        if (!rst) begin
            cnt    <= '0;
            limit  <= CNT_W'(DEF_LIMIT);
            clkout <= 1'b0;
            tick   <= 1'b0;
            busy   <= 1'b0;
        end else if (run) begin
            busy <= active;
            tick <= 1'b0;
            if (sync) begin
                cnt    <= '0;
                clkout <= 1'b0;
            end else if (wr_hit) begin
                limit <= wr_limit;
                cnt   <= '0;
            end else if (active) begin
                if (nxt >= {1'b0, limit}) begin
                    cnt    <= '0;
                    clkout <= ~clkout;
                    tick   <= ~clkout;
                end else begin
                    cnt <= nxt[CNT_W-1:0];
                end
            end
        end
    end
endmodule

module clkgen_multi #(
    parameter int NCH         = 4,
    parameter int CNT_W       = 32,
    parameter int CLK_IN_FREQ = 50000000,
    parameter int DEF_FREQ    = 1000,
    parameter int DEF_LIMIT   = CLK_IN_FREQ / 2 / DEF_FREQ
) (
    input  logic          clkin,
    input  logic          rst,
    clkgen_multi_if.slave bus
);
    logic [1:0]     rst_sync;
    logic           run;
    logic [NCH-1:0] clkout_w;
    logic [NCH-1:0] tick_w;
    logic [NCH-1:0] busy_w;

    // Reset asserts immediately but counting only starts once release has
    // crossed two flops, so no channel sees a half-released reset.
    always_ff @(posedge clkin or negedge rst) begin
        if (!rst) rst_sync <= 2'b00;
        else      rst_sync <= {rst_sync[0], 1'b1};
    end
    assign run = rst_sync[1];

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic wr_hit;
        assign wr_hit = bus.wr_en && (int'(bus.wr_ch) == i);

        clkgen_multi_ch #(
            .CNT_W     (CNT_W),
            .DEF_LIMIT (DEF_LIMIT)
        ) u_ch (
            .clkin    (clkin),
            .rst      (rst),
            .run      (run),
            .sync     (bus.sync),
            .wr_hit   (wr_hit),
            .wr_limit (bus.wr_limit),
            .en       (bus.clken[i]),
            .clkout   (clkout_w[i]),
            .tick     (tick_w[i]),
            .busy     (busy_w[i])
        );
    end

    assign bus.clkout = clkout_w;
    assign bus.tick   = tick_w;
    assign bus.busy   = busy_w;
endmodule
